// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one byte at a time and assembles
// 1..3 byte 6502 instructions for the decoder over a valid/ready handshake.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [15:0] instr_operand,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [7:0]  opcode_r, opcode_s;
    logic [15:0] operand_r, operand_s;
    logic [1:0]  len_r, len_s;
    logic [15:0] ipc_r, ipc_s;
    logic        mem_req_r;
    logic        instr_valid_r;

    // Instruction length from the opcode byte alone.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len_v;
        if ((op[3:2] == 2'b11) || ((op[3:0] == 4'h9) && op[4]) || (op == 8'h20)) begin
            len_v = 2'd3;
        end else if ((op[3:0] == 4'h8) || (op[3:0] == 4'hA) ||
                     (op == 8'h00) || (op == 8'h40) || (op == 8'h60)) begin
            len_v = 2'd1;
        end else begin
            len_v = 2'd2;
        end
        return len_v;
    endfunction

    // Next-state logic; redirect overrides every state and drops any returning byte.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        opcode_s  = opcode_r;
        operand_s = operand_r;
        len_s     = len_r;
        ipc_s     = ipc_r;
        if (redirect) begin
            state_s = ST_OP;
            pc_s    = redirect_pc;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_OP;
                end
                ST_OP: begin
                    if (mem_rvalid) begin
                        opcode_s  = mem_rdata;
                        ipc_s     = pc_r;
                        operand_s = 16'h0000;
                        pc_s      = pc_r + 16'h0001;
                        len_s     = decode_len(mem_rdata);
                        state_s   = (len_s == 2'd1) ? ST_HOLD : ST_LO;
                    end else begin
                        state_s = ST_OP;
                    end
                end
                ST_LO: begin
                    if (mem_rvalid) begin
                        operand_s[7:0] = mem_rdata;
                        pc_s           = pc_r + 16'h0001;
                        state_s        = (len_r == 2'd3) ? ST_HI : ST_HOLD;
                    end else begin
                        state_s = ST_LO;
                    end
                end
                ST_HI: begin
                    if (mem_rvalid) begin
                        operand_s[15:8] = mem_rdata;
                        pc_s            = pc_r + 16'h0001;
                        state_s         = ST_HOLD;
                    end else begin
                        state_s = ST_HI;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        state_s = ST_OP;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Registers; request and valid flags are decoded from the next state so they are flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            opcode_r      <= 8'h00;
            operand_r     <= 16'h0000;
            len_r         <= 2'd0;
            ipc_r         <= 16'h0000;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            opcode_r      <= opcode_s;
            operand_r     <= operand_s;
            len_r         <= len_s;
            ipc_r         <= ipc_s;
            mem_req_r     <= (state_s == ST_OP) || (state_s == ST_LO) || (state_s == ST_HI);
            instr_valid_r <= (state_s == ST_HOLD);
        end
    end

    assign mem_req       = mem_req_r;
    assign mem_addr      = pc_r;
    assign instr_valid   = instr_valid_r;
    assign instr_opcode  = opcode_r;
    assign instr_operand = operand_r;
    assign instr_len     = len_r;
    assign instr_pc      = ipc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus randomized traffic against a byte-counting reference model.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_req, mem_rvalid, instr_valid, instr_ready, redirect;
    logic [15:0] mem_addr, instr_operand, instr_pc, redirect_pc;
    logic [7:0]  mem_rdata, instr_opcode;
    logic [1:0]  instr_len;

    logic        rst2, req2, valid2;
    logic [15:0] addr2, operand2, pc2;
    logic [7:0]  rdata2, op2;
    logic [1:0]  len2;
    logic        rv2;

    instr_fetch #(.RESET_PC(16'h0200)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
        .instr_len(instr_len), .instr_pc(instr_pc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_fetch #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst2), .mem_req(req2), .mem_addr(addr2),
        .mem_rdata(rdata2), .mem_rvalid(rv2), .instr_valid(valid2),
        .instr_ready(1'b1), .instr_opcode(op2), .instr_operand(operand2),
        .instr_len(len2), .instr_pc(pc2), .redirect(1'b0), .redirect_pc(16'h0000)
    );

    // Wrap-around memory image for the second instance, zero-wait.
    function automatic logic [7:0] mem2_byte(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'h4C;
            16'hFFFF: return 8'h34;
            16'h0000: return 8'h12;
            16'h0001: return 8'h20;
            default:  return 8'h00;
        endcase
    endfunction
    assign rdata2 = mem2_byte(addr2);
    assign rv2    = req2;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int passes = 0;

    // Reference model: fetch pointer plus the bytes gathered so far.
    logic [15:0] m_pc, m_ipc;
    logic [7:0]  m_b [0:2];
    int          m_cnt;
    bit          m_idle, m_hold;

    function automatic int len_of(input logic [7:0] op);
        if (op[3:2] == 2'b11 || (op[3:0] == 4'h9 && op[4]) || op == 8'h20) return 3;
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input bit rv, input logic [7:0] rd, input bit rdy,
                              input bit rd_en, input logic [15:0] rpc);
        if (rd_en) begin
            m_idle = 1'b0; m_hold = 1'b0; m_cnt = 0; m_pc = rpc;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_hold) begin
            if (rdy) begin m_hold = 1'b0; m_cnt = 0; end
        end else if (rv) begin
            if (m_cnt == 0) m_ipc = m_pc;
            m_b[m_cnt] = rd;
            m_cnt++;
            m_pc = m_pc + 16'h0001;
            if (m_cnt == len_of(m_b[0])) m_hold = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_operand;
        chk("mem_req", mem_req, !m_idle && !m_hold);
        if (!m_idle && !m_hold) chk("mem_addr", mem_addr, m_pc);
        chk("instr_valid", instr_valid, m_hold);
        if (m_hold) begin
            exp_operand = (m_cnt == 3) ? {m_b[2], m_b[1]} : (m_cnt == 2) ? {8'h00, m_b[1]} : 16'h0000;
            chk("instr_opcode", instr_opcode, m_b[0]);
            chk("instr_operand", instr_operand, exp_operand);
            chk("instr_len", instr_len, m_cnt);
            chk("instr_pc", instr_pc, m_ipc);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, compare at the next falling edge.
    task automatic tick(input bit rv, input bit rdy, input bit rd_en = 1'b0, input logic [15:0] rpc = 16'h0000);
        mem_rvalid  = rv;
        mem_rdata   = rv ? mem[m_pc] : 8'($urandom);
        instr_ready = rdy;
        redirect    = rd_en;
        redirect_pc = rd_en ? rpc : 16'($urandom);
        model_step(rv, mem_rdata, rdy, rd_en, rpc);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_rvalid = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0200);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_opcode", instr_opcode, 8'h00);
        chk("rst_operand", instr_operand, 16'h0000);
        chk("rst_len", instr_len, 2'd0);
        chk("rst_pc", instr_pc, 16'h0000);
        m_idle = 1'b1; m_hold = 1'b0; m_cnt = 0; m_pc = 16'h0200; m_ipc = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; mem_rvalid = 1'b0; mem_rdata = 8'h00;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        @(negedge clk);

        // LDA #imm, zero-wait
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42; mem[16'h0202] = 8'hEA;
        do_reset();
        tick(1'b0, 1'b1); chk("t1_addr0", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0200});
        tick(1'b1, 1'b1); chk("t1_addr1", mem_addr, 16'h0201);
        tick(1'b1, 1'b1);
        chk("t1_valid", instr_valid, 1'b1);
        chk("t1_opcode", instr_opcode, 8'hA9);
        chk("t1_operand", instr_operand, 16'h0042);
        chk("t1_len", instr_len, 2'd2);
        chk("t1_pc", instr_pc, 16'h0200);
        tick(1'b0, 1'b1); chk("t1_next", mem_addr, 16'h0202);

        // JMP abs
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        do_reset();
        tick(1'b0, 1'b1); chk("t2_a0", mem_addr, 16'h0200);
        tick(1'b1, 1'b1); chk("t2_a1", mem_addr, 16'h0201);
        tick(1'b1, 1'b1); chk("t2_a2", mem_addr, 16'h0202);
        tick(1'b1, 1'b1);
        chk("t2_operand", instr_operand, 16'h1234);
        chk("t2_len", instr_len, 2'd3);
        tick(1'b0, 1'b1); chk("t2_a3", mem_addr, 16'h0203);

        // NOP held by a stalled decoder
        mem[16'h0200] = 8'hEA;
        do_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            chk("t3_hold_valid", instr_valid, 1'b1);
            chk("t3_hold_req", mem_req, 1'b0);
            chk("t3_hold_op", instr_opcode, 8'hEA);
            chk("t3_hold_len", instr_len, 2'd1);
        end
        tick(1'b0, 1'b1);
        chk("t3_next", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0201});

        // Two wait states per byte
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        do_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1); chk("t4_w0", mem_addr, 16'h0200);
        tick(1'b0, 1'b1); chk("t4_w1", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0200});
        tick(1'b1, 1'b1); chk("t4_lo", mem_addr, 16'h0201);
        tick(1'b0, 1'b1); chk("t4_w2", mem_addr, 16'h0201);
        tick(1'b0, 1'b1); chk("t4_early", instr_valid, 1'b0);
        tick(1'b1, 1'b1);
        chk("t4_valid", instr_valid, 1'b1);
        chk("t4_operand", instr_operand, 16'h0042);

        // Redirect while the operand byte returns
        mem[16'h0200] = 8'h4C; mem[16'h8000] = 8'hEA;
        do_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 16'h8000);
        chk("t5_addr", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h8000});
        chk("t5_valid", instr_valid, 1'b0);
        tick(1'b1, 1'b1);
        chk("t5_pc", instr_pc, 16'h8000);
        chk("t5_op", instr_opcode, 8'hEA);

        // Wrap-around instance, zero-wait, always ready
        rst2 = 1'b0;
        @(negedge clk); chk("t6_a0", {15'h0, req2, addr2}, {15'h0, 1'b1, 16'hFFFE});
        @(negedge clk); chk("t6_a1", addr2, 16'hFFFF);
        @(negedge clk); chk("t6_a2", addr2, 16'h0000);
        @(negedge clk);
        chk("t6_valid", valid2, 1'b1);
        chk("t6_operand", operand2, 16'h1234);
        chk("t6_pc", pc2, 16'hFFFE);
        @(negedge clk); chk("t6_next", {15'h0, req2, addr2}, {15'h0, 1'b1, 16'h0001});
        @(negedge clk);
        @(negedge clk); chk("t6_hi", addr2, 16'h0003);
        rst2 = 1'b1; #1;
        chk("t6_rst_req", req2, 1'b0);
        chk("t6_rst_addr", addr2, 16'hFFFE);
        chk("t6_rst_valid", valid2, 1'b0);
        chk("t6_rst_fields", {op2, operand2, len2, pc2}, 42'h0);
        @(negedge clk); chk("t6_rst_hold", req2, 1'b0);

        // Randomized traffic, including redirects near the top of memory
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            automatic bit rd_en = ($urandom_range(0, 39) == 0);
            automatic logic [15:0] rpc = ($urandom_range(0, 1) == 0) ?
                16'($urandom) : (16'hFFFC + 16'($urandom_range(0, 3)));
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rd_en, rpc);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
